// File: rtl/simmem_rsp_release_bank.sv
// rtl/simmem_rsp_release_bank.sv - response store released per ID by the delay bank's release vector
// Optional feature macro: SIMMEM_RSP_BANK_OCCUPANCY_EN (adds occupancy_o and its assertions)
module simmem_rsp_release_bank #(
    parameter int TotalCapacity = 16,
    parameter int IDWidth       = 4,
    parameter int DataWidth     = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [IDWidth-1:0]      in_id_i,
    input  logic [DataWidth-1:0]    in_data_i,
    input  logic [2**IDWidth-1:0]   release_en_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [IDWidth-1:0]      out_id_o,
    output logic [DataWidth-1:0]    out_data_o
`ifdef SIMMEM_RSP_BANK_OCCUPANCY_EN
    ,
    output logic [$clog2(TotalCapacity+1)-1:0] occupancy_o
`endif
);

    localparam int IdxW = $clog2(TotalCapacity);

    logic [TotalCapacity-1:0]                valid_q, valid_d;
    logic [TotalCapacity-1:0][IDWidth-1:0]   id_q, id_d;
    logic [TotalCapacity-1:0][DataWidth-1:0] data_q, data_d;
    // age_q[i][j] = 1: slot i arrived before slot j
    logic [TotalCapacity-1:0][TotalCapacity-1:0] age_q, age_d;
    logic                                    lock_vld_q, lock_vld_d;
    logic [IdxW-1:0]                         lock_idx_q, lock_idx_d;

    logic [TotalCapacity-1:0] eligible;
    logic [TotalCapacity-1:0] older_elig;
    logic [IdxW-1:0]          free_idx;
    logic [IdxW-1:0]          sel_idx;
    logic [IdxW-1:0]          cur_idx;
    logic                     in_hs;
    logic                     out_hs;

    always_comb begin
        eligible   = '0;
        older_elig = '0;
        free_idx   = '0;
        sel_idx    = '0;
        for (int i = TotalCapacity - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IdxW'(i);
            end
        end
        for (int i = 0; i < TotalCapacity; i++) begin
            eligible[i] = valid_q[i] & release_en_i[id_q[i]];
        end
        for (int i = 0; i < TotalCapacity; i++) begin
            for (int j = 0; j < TotalCapacity; j++) begin
                if (eligible[j] && age_q[j][i]) begin
                    older_elig[i] = 1'b1;
                end
            end
        end
        // Ages form a total order over valid slots, so exactly one eligible slot has no older peer
        for (int i = 0; i < TotalCapacity; i++) begin
            if (eligible[i] && !older_elig[i]) begin
                sel_idx = IdxW'(i);
            end
        end
    end

    assign in_ready_o  = ~(&valid_q);
    assign in_hs       = in_valid_i & in_ready_o;
    assign out_valid_o = lock_vld_q | (|eligible);
    assign out_hs      = out_valid_o & out_ready_i;
    assign cur_idx     = lock_vld_q ? lock_idx_q : sel_idx;
    assign out_id_o    = out_valid_o ? id_q[cur_idx] : '0;
    assign out_data_o  = out_valid_o ? data_q[cur_idx] : '0;

    always_comb begin
        valid_d    = valid_q;
        id_d       = id_q;
        data_d     = data_q;
        age_d      = age_q;
        lock_vld_d = lock_vld_q;
        lock_idx_d = lock_idx_q;
        if (in_hs) begin
            valid_d[free_idx] = 1'b1;
            id_d[free_idx]    = in_id_i;
            data_d[free_idx]  = in_data_i;
            for (int j = 0; j < TotalCapacity; j++) begin
                age_d[free_idx][j] = 1'b0;
                age_d[j][free_idx] = valid_q[j];
            end
        end
        // The release clears after the write so the departing slot leaves no stale age bits
        if (out_hs) begin
            valid_d[cur_idx] = 1'b0;
            for (int j = 0; j < TotalCapacity; j++) begin
                age_d[cur_idx][j] = 1'b0;
                age_d[j][cur_idx] = 1'b0;
            end
            lock_vld_d = 1'b0;
        end else if (out_valid_o && !lock_vld_q) begin
            lock_vld_d = 1'b1;
            lock_idx_d = sel_idx;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= '0;
            id_q       <= '0;
            data_q     <= '0;
            age_q      <= '0;
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            valid_q    <= valid_d;
            id_q       <= id_d;
            data_q     <= data_d;
            age_q      <= age_d;
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
        end
    end

`ifdef SIMMEM_RSP_BANK_OCCUPANCY_EN
    localparam int OccW = $clog2(TotalCapacity + 1);

    logic [OccW-1:0] occ_q, occ_d;

    assign occ_d       = occ_q + OccW'(in_hs) - OccW'(out_hs);
    assign occupancy_o = occ_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    a_no_write_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
        in_hs |-> !(&valid_q));
    a_occ_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
        occ_q <= OccW'(TotalCapacity));
`else
    // Occupancy tracking is absent in this build; the datapath above is unchanged.
`endif

endmodule

// File: tb/tb_simmem_rsp_release_bank.sv
// tb/tb_simmem_rsp_release_bank.sv - scoreboard bench for simmem_rsp_release_bank
module tb_simmem_rsp_release_bank;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_id;
    logic [31:0] in_data;
    logic [15:0] release_en;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_id;
    logic [31:0] out_data;
`ifdef SIMMEM_RSP_BANK_OCCUPANCY_EN
    logic [4:0]  occupancy;
`endif

    int errors = 0;
    int checks = 0;
    logic [35:0] exp_q[$];

    simmem_rsp_release_bank #(
        .TotalCapacity(16),
        .IDWidth(4),
        .DataWidth(32)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .in_id_i(in_id),
        .in_data_i(in_data),
        .release_en_i(release_en),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_id_o(out_id),
        .out_data_o(out_data)
`ifdef SIMMEM_RSP_BANK_OCCUPANCY_EN
        ,
        .occupancy_o(occupancy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write(input logic [3:0] id, input logic [31:0] data);
        in_valid = 1'b1;
        in_id    = id;
        in_data  = data;
        @(negedge clk);
        chk("in_ready_on_write", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [3:0] id, input logic [31:0] data);
        exp_q.push_back({id, data});
    endtask

    // Monitor: every accepted response is compared against the oldest expected entry
    initial begin
        logic [35:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: got id=%0h data=%0h with nothing expected", out_id, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_id, out_data} !== e) begin
                        errors++;
                        $display("FAIL rsp_order: got id=%0h data=%0h expected id=%0h data=%0h",
                                 out_id, out_data, e[35:32], e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_id      = '0;
        in_data    = '0;
        release_en = '0;
        out_ready  = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_data", {28'd0, out_id, out_data}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Stored but not released
        write(4'd3, 32'hA);
        repeat (2) @(negedge clk);
        chk("no_release_valid", {63'd0, out_valid}, 64'd0);
        chk("no_release_in_ready", {63'd0, in_ready}, 64'd1);

        // Same-ID order, back-to-back release
        @(posedge clk);
        #1;
        write(4'd3, 32'hB);
        push(4'd3, 32'hA);
        push(4'd3, 32'hB);
        release_en = 16'h0008;
        out_ready  = 1'b1;
        @(negedge clk);
        chk("same_id_first_valid", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        chk("same_id_second_valid", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        chk("same_id_drained", {63'd0, out_valid}, 64'd0);

        // Oldest across IDs first
        @(posedge clk);
        #1;
        out_ready  = 1'b0;
        release_en = '0;
        write(4'd1, 32'h11);
        write(4'd2, 32'h22);
        push(4'd1, 32'h11);
        push(4'd2, 32'h22);
        release_en = 16'h0006;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        chk("cross_id_drained", {63'd0, out_valid}, 64'd0);

        // Lock holds the presented response while release_en changes
        @(posedge clk);
        #1;
        out_ready  = 1'b0;
        release_en = '0;
        write(4'd1, 32'h11);
        write(4'd2, 32'h22);
        release_en = 16'h0004;
        @(negedge clk);
        chk("lock_present_data", {32'd0, out_data}, 64'h22);
        @(posedge clk);
        #1;
        release_en = 16'h0002;
        repeat (3) begin
            @(negedge clk);
            chk("lock_hold_valid", {63'd0, out_valid}, 64'd1);
            chk("lock_hold_data", {28'd0, out_id, out_data}, {28'd0, 4'd2, 32'h22});
        end
        @(posedge clk);
        #1;
        push(4'd2, 32'h22);
        push(4'd1, 32'h11);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("lock_drained", {63'd0, out_valid}, 64'd0);

        // Fill, reject when full, free one, refill
        @(posedge clk);
        #1;
        out_ready  = 1'b0;
        release_en = '0;
        for (int i = 0; i < 16; i++) begin
            write(4'd5, 32'h100 + i);
        end
        @(negedge clk);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
`ifdef SIMMEM_RSP_BANK_OCCUPANCY_EN
        chk("full_occupancy", {59'd0, occupancy}, 64'd16);
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_id    = 4'd5;
        in_data  = 32'hDEAD;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        push(4'd5, 32'h100);
        release_en = 16'h0020;
        out_ready  = 1'b1;
        @(negedge clk);
        chk("full_release_valid", {63'd0, out_valid}, 64'd1);
        chk("full_still_not_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        out_ready  = 1'b0;
        release_en = '0;
        @(negedge clk);
        chk("freed_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        write(4'd6, 32'h200);
        @(negedge clk);
        chk("refull_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        for (int i = 1; i < 16; i++) begin
            push(4'd5, 32'h100 + i);
        end
        push(4'd6, 32'h200);
        release_en = 16'h0060;
        out_ready  = 1'b1;
        repeat (18) @(negedge clk);
        chk("fill_drained", {63'd0, out_valid}, 64'd0);

        // Latency, lock, then reset mid-operation
        @(posedge clk);
        #1;
        out_ready  = 1'b0;
        release_en = 16'h0080;
        in_valid   = 1'b1;
        in_id      = 4'd7;
        in_data    = 32'h70;
        @(negedge clk);
        chk("latency_same_cycle", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_next_cycle", {32'd0, out_data}, 64'h70);
        @(posedge clk);
        #1;
        for (int i = 1; i < 5; i++) begin
            write(4'd7, 32'h70 + i);
        end
        @(negedge clk);
        chk("locked_oldest", {32'd0, out_data}, 64'h70);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midreset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midreset_out_data", {32'd0, out_data}, 64'd0);
`ifdef SIMMEM_RSP_BANK_OCCUPANCY_EN
        chk("midreset_occupancy", {59'd0, occupancy}, 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_reset_empty", {63'd0, out_valid}, 64'd0);
        chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
